// File: rtl/debouncer_multi_pkg.sv
// Shared types and helpers for the multi-channel button conditioner.
// Hold FSM encodings and a constant-width helper.
package debouncer_multi_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_HOLD   = 2'd1,
    STATE_LONG   = 2'd2,
    STATE_REPEAT = 2'd3
  } hold_st_e;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int unsigned clog2(input longint unsigned v);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic longint unsigned max2(
    input longint unsigned a,
    input longint unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debouncer_multi_channel.sv
// One button channel: 2-FF sync, debounce, and press/hold event FSM.
// All event outputs are registered single-cycle pulses.
module debouncer_multi_channel
  import debouncer_multi_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned HOLD_CYCLES     = 4194304,
  parameter int unsigned REPEAT_CYCLES   = 1048576,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int unsigned DW = clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HW = clog2(max2(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST =
    (REPEAT_CYCLES == 0) ? '0 : HW'(REPEAT_CYCLES - 1);
  localparam bit REP_EN = (REPEAT_CYCLES != 0);

  logic          s0_q, s1_q;
  logic          stable_q, stable_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  hold_st_e      st_q, st_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          press_q, release_q, long_q, long_d;
  logic          rep_q, rep_d;
  logic          rise, fall;

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (s1_q != stable_q) begin
      if (db_cnt_q == DB_LAST) stable_d = s1_q;
      else db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign rise = stable_d & ~stable_q;
  assign fall = ~stable_d & stable_q;

  // A debounced fall overrides any timer expiry in the same cycle.
  always_comb begin
    st_d   = st_q;
    hcnt_d = hcnt_q;
    long_d = 1'b0;
    rep_d  = 1'b0;
    if (fall) begin
      st_d   = STATE_IDLE;
      hcnt_d = '0;
    end else begin
      unique case (st_q)
        STATE_IDLE: begin
          if (rise) begin
            st_d   = STATE_HOLD;
            hcnt_d = '0;
          end
        end
        STATE_HOLD: begin
          if (hcnt_q == HOLD_LAST) begin
            st_d   = STATE_LONG;
            hcnt_d = '0;
            long_d = 1'b1;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        STATE_LONG: begin
          if (REP_EN) begin
            if (hcnt_q == REP_LAST) begin
              st_d   = STATE_REPEAT;
              hcnt_d = '0;
              rep_d  = 1'b1;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
        end
        STATE_REPEAT: begin
          if (hcnt_q == REP_LAST) begin
            hcnt_d = '0;
            rep_d  = 1'b1;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      stable_q  <= 1'b0;
      db_cnt_q  <= '0;
      st_q      <= STATE_IDLE;
      hcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      rep_q     <= 1'b0;
    end else begin
      s0_q      <= btn_raw_i ^ ACTIVE_LOW;
      s1_q      <= s0_q;
      stable_q  <= stable_d;
      db_cnt_q  <= db_cnt_d;
      st_q      <= st_d;
      hcnt_q    <= hcnt_d;
      press_q   <= rise;
      release_q <= fall;
      long_q    <= long_d;
      rep_q     <= rep_d;
    end
  end

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = rep_q;

endmodule

// File: rtl/debouncer_multi.sv
// N-channel button conditioner: independent debounce and
// press/release/long/repeat event detection per channel.
module debouncer_multi
  import debouncer_multi_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned HOLD_CYCLES     = 4194304,
  parameter int unsigned REPEAT_CYCLES   = 1048576,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_long,
  output logic [CHANNELS-1:0] btn_repeat
);

  if (CHANNELS < 1) begin : g_chk_ch
    $error("CHANNELS must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_chk_hold
    $error("HOLD_CYCLES must be >= 1");
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debouncer_multi_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw_i (btn_raw[g]),
      .level_o   (btn_level[g]),
      .press_o   (btn_press[g]),
      .release_o (btn_release[g]),
      .long_o    (btn_long[g]),
      .repeat_o  (btn_repeat[g])
    );
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: vector table plus
// hand-timed sequences for bounce, long/repeat, boundary and reset.
module tb_debouncer_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_raw;
  logic [1:0] btn_level, btn_press, btn_release;
  logic [1:0] btn_long, btn_repeat;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debouncer_multi #(
    .CHANNELS        (2),
    .DEBOUNCE_CYCLES (8),
    .HOLD_CYCLES     (32),
    .REPEAT_CYCLES   (16),
    .ACTIVE_LOW      (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .btn_repeat  (btn_repeat)
  );

  typedef struct {
    logic [1:0] raw;
    int         cyc;
    logic [9:0] exp;
    string      nm;
  } vec_t;

  vec_t tbl[20];

  function automatic logic [9:0] outs();
    return {btn_level, btn_press, btn_release, btn_long, btn_repeat};
  endfunction

  function automatic logic [9:0] o(
    input logic [1:0] lv, input logic [1:0] pr,
    input logic [1:0] rl, input logic [1:0] lg,
    input logic [1:0] rp
  );
    return {lv, pr, rl, lg, rp};
  endfunction

  function automatic vec_t mk(
    input logic [1:0] raw, input int cyc,
    input logic [9:0] exp, input string nm
  );
    vec_t v;
    v.raw = raw; v.cyc = cyc; v.exp = exp; v.nm = nm;
    return v;
  endfunction

  task automatic chk(
    input string nm, input logic [31:0] act, input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  int bad, lat, np, p_at, l_at, r_at, l_cnt, p_cnt, rp_cnt;
  int rp_at[4];

  initial begin
    tbl[0]  = mk(2'b11, 9,  o(0, 0, 0, 0, 0), "rst_pre");
    tbl[1]  = mk(2'b11, 1,  o(3, 3, 0, 0, 0), "rst_rise");
    tbl[2]  = mk(2'b11, 1,  o(3, 0, 0, 0, 0), "rst_press_w");
    tbl[3]  = mk(2'b00, 9,  o(3, 0, 0, 0, 0), "both_rel_pre");
    tbl[4]  = mk(2'b00, 1,  o(0, 0, 3, 0, 0), "both_rel");
    tbl[5]  = mk(2'b00, 1,  o(0, 0, 0, 0, 0), "both_rel_w");
    tbl[6]  = mk(2'b01, 9,  o(0, 0, 0, 0, 0), "c0_pre");
    tbl[7]  = mk(2'b01, 1,  o(1, 1, 0, 0, 0), "c0_press");
    tbl[8]  = mk(2'b01, 1,  o(1, 0, 0, 0, 0), "c0_press_w");
    tbl[9]  = mk(2'b01, 30, o(1, 0, 0, 0, 0), "c0_long_pre");
    tbl[10] = mk(2'b01, 1,  o(1, 0, 0, 1, 0), "c0_long");
    tbl[11] = mk(2'b01, 1,  o(1, 0, 0, 0, 0), "c0_long_w");
    tbl[12] = mk(2'b01, 14, o(1, 0, 0, 0, 0), "c0_rep_pre");
    tbl[13] = mk(2'b01, 1,  o(1, 0, 0, 0, 1), "c0_rep");
    tbl[14] = mk(2'b00, 1,  o(1, 0, 0, 0, 0), "c0_rep_w");
    tbl[15] = mk(2'b00, 8,  o(1, 0, 0, 0, 0), "c0_rel_pre");
    tbl[16] = mk(2'b00, 1,  o(0, 0, 1, 0, 0), "c0_rel");
    tbl[17] = mk(2'b00, 1,  o(0, 0, 0, 0, 0), "c0_rel_w");
    tbl[18] = mk(2'b10, 5,  o(0, 0, 0, 0, 0), "c1_glitch");
    tbl[19] = mk(2'b00, 12, o(0, 0, 0, 0, 0), "c1_glitch_w");

    rst_n   = 1'b0;
    btn_raw = 2'b11;
    repeat (3) @(negedge clk);
    chk("in_reset", 32'(outs()), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      btn_raw = tbl[i].raw;
      repeat (tbl[i].cyc) @(negedge clk);
      chk(tbl[i].nm, 32'(outs()), 32'(tbl[i].exp));
    end

    // Bounce on ch0: six 3-cycle phases, then a clean high.
    bad = 0;
    for (int t = 0; t < 6; t++) begin
      btn_raw[0] = (t % 2 == 0);
      repeat (3) begin
        @(negedge clk);
        if (btn_level[0] || btn_press[0]) bad++;
      end
    end
    btn_raw[0] = 1'b1;
    lat = -1; np = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (btn_press[0]) np++;
      if (btn_level[0] && lat < 0) lat = k;
    end
    chk("bounce_quiet", bad, 0);
    chk("bounce_lat", lat, 10);
    chk("bounce_npress", np, 1);
    btn_raw[0] = 1'b0;
    repeat (14) @(negedge clk);
    chk("bounce_rel", 32'(outs()), 32'd0);

    // Long press with auto-repeat on ch1.
    btn_raw = 2'b10;
    p_at = -1; l_at = -1; r_at = -1;
    p_cnt = 0; l_cnt = 0; rp_cnt = 0; bad = 0;
    for (int i = 1; i <= 130; i++) begin
      @(negedge clk);
      if (btn_press[1]) begin p_cnt++; p_at = i; end
      if (btn_long[1]) begin l_cnt++; l_at = i; end
      if (btn_repeat[1]) begin
        if (rp_cnt < 4) rp_at[rp_cnt] = i;
        rp_cnt++;
      end
      if (btn_release[1] && r_at < 0) r_at = i;
      if (btn_level[0] || btn_press[0] || btn_long[0]) bad++;
      if (i == 90) btn_raw[1] = 1'b0;
    end
    chk("lp_press_at", p_at, 10);
    chk("lp_long_at", l_at, 42);
    chk("lp_long_cnt", l_cnt, 1);
    chk("lp_rep_cnt", rp_cnt, 3);
    chk("lp_rep0", rp_at[0], 58);
    chk("lp_rep1", rp_at[1], 74);
    chk("lp_rep2", rp_at[2], 90);
    chk("lp_rel_at", r_at, 100);
    chk("lp_ch0_idle", bad, 0);

    // Debounced fall lands on the hold-expiry edge.
    btn_raw = 2'b01;
    p_at = -1; r_at = -1; l_cnt = 0; rp_cnt = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (btn_press[0] && p_at < 0) p_at = i;
      if (btn_release[0] && r_at < 0) r_at = i;
      if (btn_long[0]) l_cnt++;
      if (btn_repeat[0]) rp_cnt++;
      if (i == 32) btn_raw[0] = 1'b0;
    end
    chk("bnd_press_at", p_at, 10);
    chk("bnd_rel_at", r_at, 42);
    chk("bnd_no_long", l_cnt, 0);
    chk("bnd_no_rep", rp_cnt, 0);

    // Asynchronous reset while both channels are held.
    btn_raw = 2'b11;
    repeat (20) @(negedge clk);
    chk("pre_areset_lvl", 32'(btn_level), 32'd3);
    #3 rst_n = 1'b0;
    #1 chk("areset_drop", 32'(outs()), 32'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (outs() != 10'd0) bad++;
    end
    chk("areset_quiet", bad, 0);
    #3 rst_n = 1'b1;
    p_at = -1; bad = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (btn_press == 2'b11 && p_at < 0) p_at = k;
      if (k < 10 && outs() != 10'd0) bad++;
    end
    chk("areset_early", bad, 0);
    chk("areset_press_at", p_at, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
